// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-requester SRAM round-robin arbiter.
package sram_arb_pkg;

   localparam int ADDRESS_WIDTH     = 14;
   localparam int DATA_WIDTH        = 32;
   localparam int BE_WIDTH          = DATA_WIDTH / 8;
   localparam int SRAM_READ_LATENCY = 2;
   localparam int NUM_REQUESTERS    = 2;

   typedef struct packed {
      logic                     read_not_write;
      logic [ADDRESS_WIDTH-1:0] address;
      logic [BE_WIDTH-1:0]      byte_enable;
      logic [DATA_WIDTH-1:0]    write_data;
   } req_t;

   typedef struct packed {
      logic valid;
      logic owner;
   } tag_t;

endpackage

// File: rtl/sram_rr_arbiter_if.sv
// Requester and SRAM-side signal bundle for sram_rr_arbiter.
interface sram_rr_arbiter_if
   import sram_arb_pkg::*;
#(
   parameter int address_width = ADDRESS_WIDTH,
   parameter int data_width    = DATA_WIDTH,
   parameter int be_width      = data_width / 8
);

   logic                     req0_valid;
   logic                     req0_ready;
   logic                     req0_read_not_write;
   logic [address_width-1:0] req0_address;
   logic [be_width-1:0]      req0_byte_enable;
   logic [data_width-1:0]    req0_write_data;
   logic                     resp0_valid;
   logic [data_width-1:0]    resp0_data;

   logic                     req1_valid;
   logic                     req1_ready;
   logic                     req1_read_not_write;
   logic [address_width-1:0] req1_address;
   logic [be_width-1:0]      req1_byte_enable;
   logic [data_width-1:0]    req1_write_data;
   logic                     resp1_valid;
   logic [data_width-1:0]    resp1_data;

   logic                     sram_select;
   logic                     sram_read_not_write;
   logic [address_width-1:0] sram_address;
   logic [be_width-1:0]      sram_write_enable;
   logic [data_width-1:0]    sram_write_data;
   logic [data_width-1:0]    sram_read_data;

   // Arbiter side.
   modport slave (
      input  req0_valid, req0_read_not_write, req0_address, req0_byte_enable, req0_write_data,
      input  req1_valid, req1_read_not_write, req1_address, req1_byte_enable, req1_write_data,
      output req0_ready, resp0_valid, resp0_data,
      output req1_ready, resp1_valid, resp1_data,
      output sram_select, sram_read_not_write, sram_address, sram_write_enable, sram_write_data,
      input  sram_read_data
   );

   // Requester side (CPU/DMA).
   modport master (
      output req0_valid, req0_read_not_write, req0_address, req0_byte_enable, req0_write_data,
      output req1_valid, req1_read_not_write, req1_address, req1_byte_enable, req1_write_data,
      input  req0_ready, resp0_valid, resp0_data,
      input  req1_ready, resp1_valid, resp1_data
   );

   // Block SRAM side.
   modport sram (
      input  sram_select, sram_read_not_write, sram_address, sram_write_enable, sram_write_data,
      output sram_read_data
   );

endinterface

// File: rtl/sram_rr_arbiter_grant.sv
// Two-way round-robin grant: the requester that did not win last time wins a tie.
module sram_rr_arbiter_grant
   import sram_arb_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_REQUESTERS-1:0] req_valid_i,
   output logic                      grant_valid_o,
   output logic                      grant_owner_o
);

   logic last_grant_q, last_grant_d;

   always_comb begin
      // NOTE: every output gets a default before the case so no latch is inferred.
      grant_valid_o = 1'b0;
      grant_owner_o = 1'b0;
      last_grant_d  = last_grant_q;
      case (req_valid_i)
         2'b01: begin
            grant_valid_o = 1'b1;
            grant_owner_o = 1'b0;
         end
         2'b10: begin
            grant_valid_o = 1'b1;
            grant_owner_o = 1'b1;
         end
         2'b11: begin
            grant_valid_o = 1'b1;
            grant_owner_o = ~last_grant_q;
         end
         default: ;
      endcase
      if (grant_valid_o) last_grant_d = grant_owner_o;
   end

   // Resetting to 1 lets requester 0 win the first contended cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) last_grant_q <= 1'b1;
      // NOTE: sequential state uses non-blocking assignment so all registers update together.
      else          last_grant_q <= last_grant_d;
   end

endmodule

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter and sequencer in front of a single-port byte-write SRAM;
// registers SRAM controls and routes each read's data back to its owner.
module sram_rr_arbiter
   import sram_arb_pkg::*;
#(
   parameter int address_width = ADDRESS_WIDTH,
   parameter int data_width    = DATA_WIDTH,
   parameter int be_width      = data_width / 8
) (
   input logic              clk,
   input logic              reset_n,
   sram_rr_arbiter_if.slave bus
);

   req_t req0, req1, winner;
   logic grant_valid, grant_owner;

   logic                     sram_select_q, sram_select_d;
   logic                     sram_rnw_q, sram_rnw_d;
   logic [address_width-1:0] sram_address_q, sram_address_d;
   logic [be_width-1:0]      sram_we_q, sram_we_d;
   logic [data_width-1:0]    sram_wdata_q, sram_wdata_d;

   tag_t tag1_q, tag1_d, tag2_q;

   assign req0 = {bus.req0_read_not_write, bus.req0_address, bus.req0_byte_enable, bus.req0_write_data};
   assign req1 = {bus.req1_read_not_write, bus.req1_address, bus.req1_byte_enable, bus.req1_write_data};

   sram_rr_arbiter_grant u_grant (
      .clk           (clk),
      .reset_n       (reset_n),
      .req_valid_i   ({bus.req1_valid, bus.req0_valid}),
      .grant_valid_o (grant_valid),
      .grant_owner_o (grant_owner)
   );

   assign winner         = grant_owner ? req1 : req0;
   assign bus.req0_ready = grant_valid & ~grant_owner;
   assign bus.req1_ready = grant_valid &  grant_owner;

   // Idle cycles drop select and write enables; address/data simply hold.
   always_comb begin
      sram_select_d  = 1'b0;
      sram_we_d      = '0;
      sram_rnw_d     = sram_rnw_q;
      sram_address_d = sram_address_q;
      sram_wdata_d   = sram_wdata_q;
      tag1_d         = '0;
      if (grant_valid) begin
         sram_select_d  = 1'b1;
         sram_rnw_d     = winner.read_not_write;
         sram_address_d = winner.address;
         sram_wdata_d   = winner.write_data;
         sram_we_d      = winner.read_not_write ? '0 : winner.byte_enable;
         tag1_d         = '{valid: winner.read_not_write, owner: grant_owner};
      end
   end

   // Tag stage 1 covers the SRAM access cycle, stage 2 the data-out cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sram_select_q  <= 1'b0;
         sram_rnw_q     <= 1'b0;
         sram_address_q <= '0;
         sram_we_q      <= '0;
         sram_wdata_q   <= '0;
         tag1_q         <= '0;
         tag2_q         <= '0;
      end else begin
         sram_select_q  <= sram_select_d;
         sram_rnw_q     <= sram_rnw_d;
         sram_address_q <= sram_address_d;
         sram_we_q      <= sram_we_d;
         sram_wdata_q   <= sram_wdata_d;
         tag1_q         <= tag1_d;
         tag2_q         <= tag1_q;
      end
   end

   assign bus.sram_select         = sram_select_q;
   assign bus.sram_read_not_write = sram_rnw_q;
   assign bus.sram_address        = sram_address_q;
   assign bus.sram_write_enable   = sram_we_q;
   assign bus.sram_write_data     = sram_wdata_q;

   assign bus.resp0_valid = tag2_q.valid & ~tag2_q.owner;
   assign bus.resp1_valid = tag2_q.valid &  tag2_q.owner;
   assign bus.resp0_data  = bus.sram_read_data;
   assign bus.resp1_data  = bus.sram_read_data;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Bench for sram_rr_arbiter: behavioural SRAM, transaction-level reference model,
// directed scenarios followed by a randomized two-requester run.
module tb_sram_rr_arbiter;
   import sram_arb_pkg::*;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   sram_rr_arbiter_if bus ();

   sram_rr_arbiter dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Behavioural block SRAM with a backdoor preload port.
   logic [31:0] mem [0:16383];
   logic        bd_we = 1'b0;
   logic [13:0] bd_addr = '0;
   logic [31:0] bd_data = '0;

   always @(posedge clk) begin
      if (bd_we) mem[bd_addr] <= bd_data;
      else if (bus.sram_select) begin
         if (bus.sram_read_not_write) bus.sram_read_data <= mem[bus.sram_address];
         else
            for (int b = 0; b < 4; b++)
               if (bus.sram_write_enable[b])
                  mem[bus.sram_address][8*b +: 8] <= bus.sram_write_data[8*b +: 8];
      end
   end

   // Reference model: memory updated in acceptance order, reads queued with a due cycle.
   typedef struct {
      logic        owner;
      logic [31:0] data;
      int          due;
   } pend_t;

   pend_t       pend_q[$];
   logic [31:0] ref_mem [int];
   logic        ref_last;
   logic        exp_sel, exp_rnw;
   logic [13:0] exp_addr;
   logic [3:0]  exp_we;
   logic [31:0] exp_wdata;
   int          cyc = 0;
   logic [31:0] obs0_q[$];

   function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   task automatic model_reset();
      pend_q.delete();
      ref_last  = 1'b1;
      exp_sel   = 1'b0;
      exp_rnw   = 1'b0;
      exp_addr  = '0;
      exp_we    = '0;
      exp_wdata = '0;
   endtask

   task automatic set_req(int r, logic v, logic rnw, logic [13:0] a, logic [3:0] be, logic [31:0] d);
      if (r == 0) begin
         bus.req0_valid = v; bus.req0_read_not_write = rnw; bus.req0_address = a;
         bus.req0_byte_enable = be; bus.req0_write_data = d;
      end else begin
         bus.req1_valid = v; bus.req1_read_not_write = rnw; bus.req1_address = a;
         bus.req1_byte_enable = be; bus.req1_write_data = d;
      end
   endtask

   task automatic preload(logic [13:0] a, logic [31:0] d);
      ref_mem[int'(a)] = d;
      bd_we = 1'b1; bd_addr = a; bd_data = d;
      @(posedge clk); #1;
      bd_we = 1'b0;
   endtask

   // One clock: compare at the falling edge, advance the model, return 1 time unit after the rising edge.
   task automatic tick();
      logic v0, v1, acc, own, rnw, er0, er1;
      logic [13:0] a;
      logic [3:0]  be;
      logic [31:0] wd;
      @(negedge clk);
      if (!reset_n) model_reset();
      v0  = bus.req0_valid & reset_n;
      v1  = bus.req1_valid & reset_n;
      acc = v0 | v1;
      own = (v0 && v1) ? ~ref_last : v1;
      check("req0_ready", bus.req0_ready, acc & ~own);
      check("req1_ready", bus.req1_ready, acc & own);
      check("sram_select", bus.sram_select, exp_sel);
      check("sram_rnw", bus.sram_read_not_write, exp_rnw);
      check("sram_address", bus.sram_address, exp_addr);
      check("sram_we", bus.sram_write_enable, exp_we);
      check("sram_wdata", bus.sram_write_data, exp_wdata);
      er0 = 1'b0; er1 = 1'b0;
      if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
         er0 = ~pend_q[0].owner;
         er1 = pend_q[0].owner;
      end
      check("resp0_valid", bus.resp0_valid, er0);
      check("resp1_valid", bus.resp1_valid, er1);
      if (er0) check("resp0_data", bus.resp0_data, pend_q[0].data);
      if (er1) check("resp1_data", bus.resp1_data, pend_q[0].data);
      if (er0 || er1) void'(pend_q.pop_front());
      if (bus.resp0_valid) obs0_q.push_back(bus.resp0_data);
      if (acc) begin
         rnw = own ? bus.req1_read_not_write : bus.req0_read_not_write;
         a   = own ? bus.req1_address        : bus.req0_address;
         be  = own ? bus.req1_byte_enable    : bus.req0_byte_enable;
         wd  = own ? bus.req1_write_data     : bus.req0_write_data;
         exp_sel = 1'b1; exp_rnw = rnw; exp_addr = a; exp_wdata = wd;
         exp_we  = rnw ? 4'h0 : be;
         ref_last = own;
         if (!ref_mem.exists(int'(a))) ref_mem[int'(a)] = 32'h0;
         if (rnw) pend_q.push_back('{owner: own, data: ref_mem[int'(a)], due: cyc + SRAM_READ_LATENCY});
         else     ref_mem[int'(a)] = merge(ref_mem[int'(a)], wd, be);
      end else begin
         exp_sel = 1'b0;
         exp_we  = 4'h0;
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   initial begin
      set_req(0, 0, 0, '0, '0, '0);
      set_req(1, 0, 0, '0, '0, '0);
      model_reset();
      #1;
      preload(14'h0123, 32'h11223344);
      preload(14'h3FFF, 32'h5A5A1234);
      for (int i = 0; i < 8; i++) preload(14'h0010 + 14'(i), $urandom);

      // Reset state, then idle.
      tick(); tick();
      reset_n = 1'b1;
      repeat (10) tick();

      // Partial write then read-back of the merged word.
      obs0_q.delete();
      set_req(0, 1, 0, 14'h0123, 4'b0101, 32'hAABBCCDD); tick();
      set_req(0, 1, 1, 14'h0123, 4'hF, 32'h0); tick();
      set_req(0, 0, 0, '0, '0, '0);
      repeat (4) tick();
      check("wr_rd_resp_count", obs0_q.size(), 1);
      if (obs0_q.size() >= 1) check("wr_rd_merged", obs0_q[0], 32'h11BB33DD);

      // Both requesters reading continuously from the first cycle after reset.
      reset_n = 1'b0; tick(); reset_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         set_req(0, 1, 1, 14'h0010 + 14'($urandom_range(0, 7)), 4'h0, 32'h0);
         set_req(1, 1, 1, 14'h0010 + 14'($urandom_range(0, 7)), 4'h0, 32'h0);
         tick();
      end
      set_req(0, 0, 0, '0, '0, '0);
      set_req(1, 0, 0, '0, '0, '0);
      repeat (3) tick();

      // Requester 1 alone for three cycles, then contention.
      set_req(1, 1, 1, 14'h0011, 4'h0, 32'h0);
      repeat (3) tick();
      set_req(0, 1, 1, 14'h0012, 4'h0, 32'h0);
      #1;
      check("contended_req0_wins", {bus.req1_ready, bus.req0_ready}, 2'b01);
      tick();
      set_req(0, 0, 0, '0, '0, '0);
      set_req(1, 0, 0, '0, '0, '0);
      repeat (3) tick();

      // Reset pulsed while a read is in flight.
      set_req(0, 1, 1, 14'h0123, 4'h0, 32'h0); tick();
      set_req(0, 0, 0, '0, '0, '0);
      #1;
      check("select_before_reset", bus.sram_select, 1'b1);
      reset_n = 1'b0;
      #1;
      check("select_on_reset", bus.sram_select, 1'b0);
      tick();
      reset_n = 1'b1;
      obs0_q.delete();
      repeat (4) tick();
      check("no_resp_after_reset", obs0_q.size(), 0);

      // Read then write the top address back-to-back, then read again.
      obs0_q.delete();
      set_req(0, 1, 1, 14'h3FFF, 4'h0, 32'h0); tick();
      set_req(0, 1, 0, 14'h3FFF, 4'hF, 32'hFFFFFFFF); tick();
      set_req(0, 1, 1, 14'h3FFF, 4'h0, 32'h0); tick();
      set_req(0, 0, 0, '0, '0, '0);
      repeat (4) tick();
      check("rw_resp_count", obs0_q.size(), 2);
      if (obs0_q.size() >= 2) begin
         check("rw_old_data", obs0_q[0], 32'h5A5A1234);
         check("rw_new_data", obs0_q[1], 32'hFFFFFFFF);
      end

      // Randomized traffic from both requesters.
      repeat (300) begin
         set_req(0, 1'($urandom), 1'($urandom), 14'h0010 + 14'($urandom_range(0, 7)),
                 4'($urandom), $urandom);
         set_req(1, 1'($urandom), 1'($urandom), 14'h0010 + 14'($urandom_range(0, 7)),
                 4'($urandom), $urandom);
         tick();
      end
      set_req(0, 0, 0, '0, '0, '0);
      set_req(1, 0, 0, '0, '0, '0);
      repeat (4) tick();
      check("pending_drained", pend_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_rr_arbiter.md
Name: sram_rr_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the single-port 16384x32 byte-write-enable block SRAM.
- Accepts one request per cycle and drives registered SRAM control signals.
- Tracks which requester owns each in-flight read and returns that read's data to that requester only.
- Sits between the CPU/DMA masters and the BRAM wrapper; the SRAM's own enable is tied high.

Parameters:
- address_width, 14, SRAM word-address width
- data_width, 32, SRAM data width; must be a multiple of 8
- be_width, data_width/8, number of byte write enables

Ports:
- clk  in  1  single clock, also drives the SRAM
- reset_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has a request
- req0_ready  out  1  request 0 accepted this cycle
- req0_read_not_write  in  1  1=read, 0=write
- req0_address  in  address_width  word address
- req0_byte_enable  in  be_width  byte write enables (ignored on reads)
- req0_write_data  in  data_width  write data
- resp0_valid  out  1  read data for requester 0 valid
- resp0_data  out  data_width  read data
- req1_* / resp1_*  same set for requester 1
- sram_select  out  1  SRAM access this cycle
- sram_read_not_write  out  1  to SRAM
- sram_address  out  address_width  to SRAM
- sram_write_enable  out  be_width  to SRAM
- sram_write_data  out  data_width  to SRAM
- sram_read_data  in  data_width  SRAM data_out; valid the cycle after the access edge

Behaviour:
- Reset values:
  - All sram_* registers are 0.
  - resp0_valid and resp1_valid are 0.
  - last_grant is 1, so requester 0 wins first.
  - Both in-flight tag stages are invalid.
- Arbitration (combinational in cycle N):
  - Only req0_valid set: grant 0.
  - Only req1_valid set: grant 1.
  - Both set: grant the requester that is not last_grant.
- Handshake:
  - reqX_ready = grant to X in the same cycle.
  - reqX_ready never asserts without reqX_valid.
  - At most one ready per cycle.
  - The arbiter never stalls; an accept is possible every cycle.
- Acceptance in cycle N:
  - On the next edge, register sram_select=1, sram_read_not_write, sram_address and sram_write_data from the winner.
  - sram_write_enable = byte_enable when writing, 0 when reading.
  - last_grant becomes the winner.
- No acceptance in cycle N: on the next edge sram_select=0 and sram_write_enable=0; the other sram_* hold their values.
- SRAM access occurs on the edge ending cycle N+1.
- Read latency:
  - Tag stage 1 holds {valid, owner} in cycle N+1; tag stage 2 holds it in cycle N+2.
  - In cycle N+2, respX_valid=1 only for the owning requester.
  - respX_data = sram_read_data, driven combinationally to both response ports; consumers qualify it with respX_valid.
- Writes produce no response; completion is the acceptance cycle.
- Back-to-back accepts:
  - Reads on consecutive cycles return on consecutive cycles in order.
  - A write followed by a read to the same address returns the new data (the SRAM completes the write first).
  - Read then write to the same address returns the old data.
- Reset mid-operation:
  - All in-flight tags are cleared and pending responses are dropped.
  - No respX_valid may assert in the two cycles after reset release unless new reads were accepted.

Decomposition:
- Shared package sram_arb_pkg holds:
  - Request struct {read_not_write, address, byte_enable, write_data}.
  - Tag struct {valid, owner}.
  - Constants SRAM_READ_LATENCY=2 (accept to response) and NUM_REQUESTERS=2.
- One natural sub-module: sram_rr_arbiter_grant, the 2-way round-robin grant logic with the last_grant register.
- The read-tag pipeline and SRAM control registers live in the top module.

Test Plan:
- Reset, no requests -> all outputs 0 for 10 cycles; sram_select=0.
- req0 write addr 0x0123, be=4'b0101, data 0xAABBCCDD, then req0 read 0x0123 with the SRAM preloaded 0x11223344 -> resp0_valid 2 cycles after the read accept, resp0_data=0x11BB33DD, resp1_valid stays 0.
- Both requesters hold valid reads continuously from the first cycle after reset -> grants alternate 0,1,0,1 (requester 0 first since last_grant resets to 1); responses alternate owner in the same order at latency 2.
- Only req1 valid for 3 cycles, then both valid -> req0 wins the first contended cycle.
- Read issued, reset_n pulsed low in cycle N+1 -> no respX_valid after reset release; sram_select=0 immediately on reset assertion.
- Read 0x3FFF then write 0x3FFF data 0xFFFFFFFF be=4'hF back-to-back -> the read returns the old contents; a later read returns 0xFFFFFFFF.
